// File: rtl/alu_exec_pipe.sv
// Registered execute-stage ALU with valid/ready handshakes on both sides.
// Define ALU_EXEC_MUL_EN to build the iterative shift-add multiplier for opcode 111.
module alu_exec_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       control,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             equal,
  output logic             carry,
  output logic             illegal,
  output logic             busy
);

  logic             r_outValid;
  logic [WIDTH-1:0] r_result;
  logic             r_equal;
  logic             r_carry;
  logic             r_illegal;

  logic             w_outFree;
  logic             w_inReady;
  logic             w_accept;
  logic             w_singleLoad;
  logic             w_load;
  logic [WIDTH-1:0] w_aluResult;
  logic             w_aluCarry;
  logic             w_aluIllegal;
  logic [WIDTH-1:0] w_nextResult;
  logic             w_nextEqual;
  logic             w_nextCarry;
  logic             w_nextIllegal;

  assign w_outFree = !r_outValid || out_ready;
  assign w_accept  = in_valid && w_inReady;

  always_comb begin
    w_aluResult  = '0;
    w_aluCarry   = 1'b0;
    w_aluIllegal = 1'b0;
    case (control)
      3'b000: {w_aluCarry, w_aluResult} = {1'b0, opA} + {1'b0, opB};
      3'b001: w_aluResult = opA | opB;
      3'b010: w_aluResult = opA & opB;
      3'b011: w_aluResult = ~opA;
      3'b100: begin
        w_aluResult = opA - opB;
        w_aluCarry  = (opA >= opB);
      end
      3'b101: w_aluResult = opA << opB[SHW-1:0];
      3'b110: w_aluResult = opA >> opB[SHW-1:0];
      default: begin
`ifdef ALU_EXEC_MUL_EN
        w_aluResult = '0;
`else
        w_aluIllegal = 1'b1;
`endif
      end
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  state_t             r_state;
  logic [2*WIDTH-1:0] r_mulA;
  logic [WIDTH-1:0]   r_mulB;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_mulEq;
  logic [CW-1:0]      r_count;

  logic w_isMul;
  logic w_mulStart;
  logic w_mulLoad;

  assign w_isMul      = (control == 3'b111);
  assign w_inReady    = (r_state == IDLE) && w_outFree;
  assign w_mulStart   = w_accept && w_isMul;
  assign w_singleLoad = w_accept && !w_isMul;
  assign w_mulLoad    = (r_state == HOLD) && w_outFree;
  assign busy         = (r_state != IDLE);

  // Operands are latched on accept, then one partial product is folded in per cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_mulA  <= '0;
      r_mulB  <= '0;
      r_acc   <= '0;
      r_mulEq <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mulStart) begin
            r_mulA  <= {{WIDTH{1'b0}}, opA};
            r_mulB  <= opB;
            r_acc   <= '0;
            r_mulEq <= (opA == opB);
            r_count <= '0;
            r_state <= MUL;
          end
        end
        MUL: begin
          if (r_mulB[0]) begin
            r_acc <= r_acc + r_mulA;
          end
          r_mulA  <= r_mulA << 1;
          r_mulB  <= r_mulB >> 1;
          r_count <= r_count + CW'(1);
          if (r_count == CW'(WIDTH - 1)) begin
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_outFree) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`else
  assign w_inReady    = w_outFree;
  assign w_singleLoad = w_accept;
  assign busy         = 1'b0;
`endif

  always_comb begin
    w_load        = w_singleLoad;
    w_nextResult  = w_aluResult;
    w_nextEqual   = (opA == opB);
    w_nextCarry   = w_aluCarry;
    w_nextIllegal = w_aluIllegal;
`ifdef ALU_EXEC_MUL_EN
    if (w_mulLoad) begin
      w_load        = 1'b1;
      w_nextResult  = r_acc[WIDTH-1:0];
      w_nextEqual   = r_mulEq;
      w_nextCarry   = |r_acc[2*WIDTH-1:WIDTH];
      w_nextIllegal = 1'b0;
    end
`endif
  end

  // A new load wins over a same-edge drain so back-to-back results keep out_valid high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_equal    <= 1'b0;
      r_carry    <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_load) begin
      r_outValid <= 1'b1;
      r_result   <= w_nextResult;
      r_equal    <= w_nextEqual;
      r_carry    <= w_nextCarry;
      r_illegal  <= w_nextIllegal;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign in_ready  = w_inReady;
  assign out_valid = r_outValid;
  assign result    = r_result;
  assign equal     = r_equal;
  assign carry     = r_carry;
  assign illegal   = r_illegal;

endmodule
